shift3_ctrl: RTL

SHIFT3_CTRL -- requirements
Module: shift3_ctrl

---
 rtl/shift3_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift3_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift3_ctrl
//  Description : Handshake controller and 3-stage 4-bit delay-line chain with
//                IDLE/RUN/FLUSH sequencing, occupancy tracking and counters.
//  Revision    : 1.0  initial release
// ============================================================================
module shift3_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       Flush,
    input  logic       In_valid,
    output logic       In_ready,
    input  logic [3:0] Din,
    output logic       Out_valid,
    input  logic       Out_ready,
    output logic [3:0] Dout,
    output logic       Ce,
    output logic [2:0] Vld,
    output logic [1:0] Level,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Acc_cnt,
    output logic [7:0] Emit_cnt
);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_RUN   = 2'd1;
    localparam logic [1:0] C_ST_FLUSH = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] vld_q, vld_d;
    logic [1:0] level_q, level_d;
    logic [7:0] acc_q, emit_q;
    logic       done_q, done_d;
    logic [3:0] s1_q, s2_q, s3_q;

    logic       w_stall;
    logic       w_accept;
    logic       w_consume;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (Enable) state_d = C_ST_RUN;
            end
            C_ST_RUN: begin
                // Flush outranks a dropped Enable
                if (Flush)        state_d = C_ST_FLUSH;
                else if (!Enable) state_d = C_ST_IDLE;
            end
            C_ST_FLUSH: begin
                if (vld_q == 3'b000) state_d = Enable ? C_ST_RUN : C_ST_IDLE;
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted
    always_comb begin
        w_stall   = vld_q[2] & ~Out_ready;
        In_ready  = ~RST & (state_q == C_ST_RUN) & ~w_stall;
        w_accept  = In_valid & In_ready;
        Ce        = ~RST & (w_accept |
                    ((state_q == C_ST_FLUSH) & (vld_q[1] | vld_q[0]) & ~w_stall));
        Out_valid = ~RST & vld_q[2];
        w_consume = Out_valid & Out_ready;
        Busy      = (state_q == C_ST_FLUSH);
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        vld_d = vld_q;
        if (Ce) begin
            // accept is 0 in FLUSH, so a bubble enters stage 1 there
            vld_d = {vld_q[1:0], w_accept};
        end else if (w_consume) begin
            vld_d = {1'b0, vld_q[1:0]};
        end
        level_d = {1'b0, vld_d[0]} + {1'b0, vld_d[1]} + {1'b0, vld_d[2]};
        done_d  = (state_q == C_ST_FLUSH) && (state_d != C_ST_FLUSH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q   <= 3'b000;
            level_q <= 2'd0;
            acc_q   <= 8'd0;
            emit_q  <= 8'd0;
            done_q  <= 1'b0;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            s3_q    <= 4'd0;
        end else begin
            vld_q   <= vld_d;
            level_q <= level_d;
            done_q  <= done_d;
            if (w_accept)  acc_q  <= acc_q + 8'd1;
            if (w_consume) emit_q <= emit_q + 8'd1;
            if (Ce) begin
                s1_q <= Din;
                s2_q <= s1_q;
                s3_q <= s2_q;
            end
        end
    end

    assign Vld      = vld_q;
    assign Level    = level_q;
    assign Done     = done_q;
    assign Acc_cnt  = acc_q;
    assign Emit_cnt = emit_q;
    assign Dout     = s3_q;

endmodule
`default_nettype wire
